receptor_nbytes: RTL
====================

RECEPTOR_NBYTES -- requirements
Module: receptor_nbytes

Interface
REQ-001 SHALL have parameter BAUD_RATE, default 115200, serial bit rate.
REQ-002 SHALL have parameter CLOCK_HZ, default 50_000_000, clock frequency.
REQ-003 SHALL have parameter N_BYTES, default 2, range 1..8, bytes per word.
REQ-004 SHALL have parameter PARITY, default 1: 0 = none, 1 = even, 2 = odd.
REQ-005 SHALL have parameter TIMEOUT_BITS, default 20, inter-byte idle limit in bit-times.
REQ-006 SHALL have port clock, input, 1, single system clock, rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous, active-low.
REQ-008 SHALL have port rx_serial, input, 1, asynchronous serial line, idle high.
REQ-009 SHALL have port data_out, output, 8*N_BYTES, last good word; first received byte in the MS byte.
REQ-010 SHALL have port pronto, output, 1, one-cycle pulse when a word is complete.
REQ-011 SHALL have port erro, output, 1, one-cycle pulse when a word is aborted.
REQ-012 SHALL have port erro_codigo, output, 2, error code: 00 none, 01 parity, 10 framing, 11 timeout.
REQ-013 SHALL have port ocupado, output, 1, high while a word is in progress.

Function
REQ-014 SHALL pass rx_serial through a 2-flop synchronizer before any use.
REQ-015 SHALL use CLKS_PER_BIT = CLOCK_HZ/BAUD_RATE, truncated.
REQ-016 SHALL treat a synchronized falling edge as a start, then recheck the line at CLKS_PER_BIT/2.
REQ-017 SHALL treat a high line at that recheck as a false start: return to idle, no error, no flag.
REQ-018 SHALL sample 8 data bits LSB-first at bit centres.
REQ-019 SHALL then sample a parity bit if PARITY≠0, then one stop bit.
REQ-020 SHALL run a word FSM with states IDLE, RECV, WAIT_NEXT, DONE, ERROR.
REQ-021 SHALL move IDLE→RECV on a valid start; byte counter cleared.
REQ-022 SHALL move RECV→WAIT_NEXT after a good byte with count < N_BYTES-1.
REQ-023 SHALL move RECV→DONE after a good byte with count = N_BYTES-1.
REQ-024 SHALL move WAIT_NEXT→RECV on the next valid start.
REQ-025 SHALL move DONE→IDLE after one cycle.
REQ-026 SHALL move any RECV byte failure→ERROR→IDLE (one cycle in ERROR).
REQ-027 SHALL flag a parity mismatch as code 01; a stop bit sampled low SHALL be code 10.
REQ-028 SHALL, in DONE, load data_out, pulse pronto and set erro_codigo=00 in the same cycle, one cycle after the final stop-bit sample.
REQ-029 SHALL, in ERROR, pulse erro, load erro_codigo and discard the partial word; data_out keeps its prior value.
REQ-030 SHALL hold erro_codigo until the next pronto or erro.
REQ-031 SHALL, after a framing error, ignore starts until the line has been high for one full bit-time.
REQ-032 SHALL drive ocupado high in RECV and WAIT_NEXT only.
REQ-033 SHALL never assert pronto and erro in the same cycle.
REQ-034 SHALL, when N_BYTES=1, never enter WAIT_NEXT.

Reset
REQ-035 SHALL, on reset low, immediately set the FSM to IDLE, counters to 0 and data_out to 0.
REQ-036 SHALL, on reset low, set pronto, erro and ocupado to 0 and erro_codigo to 00.
REQ-037 SHALL treat a frame in flight at reset as discarded, with no error reported after release.
REQ-038 SHALL preset the synchronizer flops to 1.

Configuration
REQ-039 SHALL compile the inter-byte timeout in only with macro RECEPTOR_TIMEOUT_EN defined.
REQ-040 SHALL, with the macro defined, take WAIT_NEXT→ERROR with code 11 once the line stays idle TIMEOUT_BITS*CLKS_PER_BIT cycles.
REQ-041 SHALL, without the macro, wait in WAIT_NEXT indefinitely, never produce code 11, ignore TIMEOUT_BITS and contain no timeout counter.

Structure
REQ-042 SHALL take the FSM state enum and the erro_codigo constants from shared package receptor_pkg.
REQ-043 SHALL implement the bit-level engine as one sub-module rx_byte_engine (sync, baud count, shift, parity, stop check, byte_ok and byte_err pulses).
REQ-044 SHALL implement the word FSM and assembly register in receptor_nbytes.

Verification
Bench settings: CLOCK_HZ=1_000_000, BAUD_RATE=100_000 (10 clocks/bit), N_BYTES=2, PARITY=1 unless stated.
REQ-045 SHALL cover: bytes 0xA5 then 0x3C with correct even parity -> single pronto, data_out=16'hA53C, erro_codigo=00.
REQ-046 SHALL cover: second byte 0x3C with its parity bit inverted -> erro pulse, erro_codigo=01, data_out unchanged.
REQ-047 SHALL cover: first byte stop bit held low -> erro_codigo=10, and a start within 1 bit-time of the bad stop is ignored.
REQ-048 SHALL cover: 3-clock low glitch on an idle line -> no state change, no pronto, no erro.
REQ-049 SHALL cover: with RECEPTOR_TIMEOUT_EN defined, one byte then idle 200 cycles -> erro, erro_codigo=11; with it undefined -> ocupado stays 1.
REQ-050 SHALL cover: reset pulsed low mid second byte -> all outputs zero; the next full word 0x1234 gives pronto with data_out=16'h1234.

Source files
------------

// File: rtl/receptor_pkg.sv
// receptor_pkg: word/bit state enums and error codes shared by the receptor blocks
package receptor_pkg;
  typedef enum logic [2:0] {S_IDLE, S_RECV, S_WAIT_NEXT, S_DONE, S_ERROR} word_state_t;
  typedef enum logic [2:0] {E_IDLE, E_START, E_DATA, E_PAR, E_STOP, E_HOLD} bit_state_t;
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_PARITY  = 2'b01;
  localparam logic [1:0] ERR_FRAME   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;
endpackage

// File: rtl/rx_byte_engine.sv
// rx_byte_engine: synchronized UART byte receiver with parity/stop checking and result pulses
module rx_byte_engine
  import receptor_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY       = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_serial,
  output logic [7:0] byte_data,
  output logic       start_ok,
  output logic       byte_ok,
  output logic       byte_err,
  output logic [1:0] err_code
);
  localparam int CW   = $clog2(CLKS_PER_BIT) + 1;
  localparam int HALF = CLKS_PER_BIT / 2;
  bit_state_t st;
  logic [1:0] sync;
  logic rx_s, rx_q, par_bad, tick;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] sh;
  assign rx_s = sync[1];
  assign tick = cnt == CW'(CLKS_PER_BIT - 1);
  assign byte_data = sh;
  // Reset lands in E_HOLD so a frame cut by reset cannot be mistaken for a new start.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync     <= 2'b11;
      rx_q     <= 1'b1;
      st       <= E_HOLD;
      cnt      <= '0;
      idx      <= '0;
      sh       <= '0;
      par_bad  <= 1'b0;
      start_ok <= 1'b0;
      byte_ok  <= 1'b0;
      byte_err <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      sync     <= {sync[0], rx_serial};
      rx_q     <= rx_s;
      start_ok <= 1'b0;
      byte_ok  <= 1'b0;
      byte_err <= 1'b0;
      case (st)
        E_IDLE: if (rx_q && !rx_s) begin
          st  <= E_START;
          cnt <= '0;
        end
        E_START: if (cnt == CW'(HALF - 1)) begin
          cnt <= '0;
          if (rx_s) st <= E_IDLE;
          else begin
            st       <= E_DATA;
            idx      <= '0;
            par_bad  <= 1'b0;
            start_ok <= 1'b1;
          end
        end else cnt <= cnt + 1'b1;
        E_DATA: if (tick) begin
          cnt <= '0;
          sh  <= {rx_s, sh[7:1]};
          idx <= idx + 1'b1;
          if (idx == 3'd7) st <= (PARITY != 0) ? E_PAR : E_STOP;
        end else cnt <= cnt + 1'b1;
        E_PAR: if (tick) begin
          cnt     <= '0;
          par_bad <= (^sh ^ rx_s) != (PARITY == 2);
          st      <= E_STOP;
        end else cnt <= cnt + 1'b1;
        E_STOP: if (tick) begin
          cnt <= '0;
          if (!rx_s) begin
            st       <= E_HOLD;
            byte_err <= 1'b1;
            err_code <= ERR_FRAME;
          end else if (par_bad) begin
            st       <= E_IDLE;
            byte_err <= 1'b1;
            err_code <= ERR_PARITY;
          end else begin
            st      <= E_IDLE;
            byte_ok <= 1'b1;
          end
        end else cnt <= cnt + 1'b1;
        E_HOLD: if (!rx_s) cnt <= '0;
        else if (tick) begin
          st  <= E_IDLE;
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
        default: st <= E_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/receptor_nbytes.sv
// receptor_nbytes: assembles N_BYTES UART bytes into a word, MS byte first
// Define RECEPTOR_TIMEOUT_EN to abort a word when the line idles too long between bytes.
module receptor_nbytes
  import receptor_pkg::*;
#(
  parameter int BAUD_RATE    = 115200,
  parameter int CLOCK_HZ     = 50_000_000,
  parameter int N_BYTES      = 2,
  parameter int PARITY       = 1,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   rx_serial,
  output logic [8*N_BYTES-1:0]   data_out,
  output logic                   pronto,
  output logic                   erro,
  output logic [1:0]             erro_codigo,
  output logic                   ocupado
);
  localparam int CLKS_PER_BIT = CLOCK_HZ / BAUD_RATE;
  localparam int W = 8 * N_BYTES;
  word_state_t state;
  logic [7:0] byte_data;
  logic start_ok, byte_ok, byte_err;
  logic [1:0] err_code;
  logic [3:0] cnt;
  logic [W-1:0] asm_q, asm_nx;
  assign asm_nx = W'({asm_q, byte_data});
  rx_byte_engine #(.CLKS_PER_BIT(CLKS_PER_BIT), .PARITY(PARITY)) u_eng (
    .clock(clock), .reset(reset), .rx_serial(rx_serial), .byte_data(byte_data),
    .start_ok(start_ok), .byte_ok(byte_ok), .byte_err(byte_err), .err_code(err_code)
  );
`ifdef RECEPTOR_TIMEOUT_EN
  localparam int TO = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW = $clog2(TO + 1);
  logic [TW-1:0] to_cnt;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) to_cnt <= '0;
    else to_cnt <= (state == S_WAIT_NEXT && !start_ok) ? to_cnt + 1'b1 : '0;
  end
`endif
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      asm_q       <= '0;
      data_out    <= '0;
      pronto      <= 1'b0;
      erro        <= 1'b0;
      erro_codigo <= ERR_NONE;
      ocupado     <= 1'b0;
    end else begin
      pronto <= 1'b0;
      erro   <= 1'b0;
      case (state)
        S_IDLE: if (start_ok) begin
          state   <= S_RECV;
          cnt     <= '0;
          asm_q   <= '0;
          ocupado <= 1'b1;
        end
        S_RECV: if (byte_err) begin
          state       <= S_ERROR;
          erro        <= 1'b1;
          erro_codigo <= err_code;
          ocupado     <= 1'b0;
        end else if (byte_ok) begin
          if (cnt == 4'(N_BYTES - 1)) begin
            state       <= S_DONE;
            data_out    <= asm_nx;
            pronto      <= 1'b1;
            erro_codigo <= ERR_NONE;
            ocupado     <= 1'b0;
          end else begin
            state <= S_WAIT_NEXT;
            asm_q <= asm_nx;
            cnt   <= cnt + 1'b1;
          end
        end
        S_WAIT_NEXT: if (start_ok) state <= S_RECV;
`ifdef RECEPTOR_TIMEOUT_EN
        else if (to_cnt == TW'(TO - 1)) begin
          state       <= S_ERROR;
          erro        <= 1'b1;
          erro_codigo <= ERR_TIMEOUT;
          ocupado     <= 1'b0;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
